// File: rtl/relogio_set_ctrl.sv
// Time-set and tick controller for the HH:MM:SS clock: key debounce, RUN/SET mode FSM,
// 1 Hz count enable, blink strobe and per-field set pulses. Define RELOGIO_SET_AUTOREPEAT_EN for inc hold-to-repeat.
module relogio_set_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       main_clock,
    input  logic       main_reset,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [1:0] state,
    output logic       tick_1hz,
    output logic       inc_h,
    output logic       inc_m,
    output logic       clr_s,
    output logic       blink
);

    localparam int PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BLINK_DIV = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    mode_t cur;
    mode_t nxt;

    // Bit 0 carries the mode key, bit 1 the inc key.
    logic [1:0] keys;
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] deb;
    logic [1:0] deb_d;
    logic [DEB_W-1:0] deb_cnt [2];

    logic mode_press;
    logic inc_press;
    logic rpt_fire;

    logic inc_h_nxt;
    logic inc_m_nxt;
    logic clr_s_nxt;

    logic [PRESC_W-1:0] presc;
    logic [BLINK_W-1:0] blink_cnt;

    assign keys = {key_inc, key_mode};

    always_ff @(posedge main_clock) begin
        if (!main_reset) begin
            sync_a     <= 2'b11;
            sync_b     <= 2'b11;
            deb        <= 2'b11;
            deb_d      <= 2'b11;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_a <= keys;
            sync_b <= sync_a;
            deb_d  <= deb;
            for (int k = 0; k < 2; k++) begin
                if (sync_b[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb[k]     <= sync_b[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Only the debounced falling edge counts; a simultaneous mode press swallows inc.
    assign mode_press = deb_d[0] & ~deb[0];
    assign inc_press  = deb_d[1] & ~deb[1] & ~mode_press;

`ifdef RELOGIO_SET_AUTOREPEAT_EN
    localparam int HOLD_FIRST = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int HOLD_NEXT  = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int HOLD_W     = (HOLD_FIRST > 1) ? $clog2(HOLD_FIRST) : 1;

    logic              rpt_active;
    logic              rpt_first;
    logic [HOLD_W-1:0] rpt_cnt;

    assign rpt_fire = rpt_active && !deb[1] && !mode_press &&
                      (rpt_cnt == (rpt_first ? HOLD_W'(HOLD_FIRST - 1) : HOLD_W'(HOLD_NEXT - 1)));

    always_ff @(posedge main_clock) begin
        if (!main_reset) begin
            rpt_active <= 1'b0;
            rpt_first  <= 1'b0;
            rpt_cnt    <= '0;
        end else if (inc_press && (cur == SET_H || cur == SET_M)) begin
            rpt_active <= 1'b1;
            rpt_first  <= 1'b1;
            rpt_cnt    <= '0;
        end else if (rpt_active) begin
            if (deb[1] || mode_press) begin
                rpt_active <= 1'b0;
                rpt_cnt    <= '0;
            end else if (rpt_fire) begin
                rpt_first <= 1'b0;
                rpt_cnt   <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge main_clock) begin
        if (!main_reset) begin
            cur <= RUN;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (mode_press) begin
            case (cur)
                RUN:     nxt = SET_H;
                SET_H:   nxt = SET_M;
                SET_M:   nxt = SET_S;
                default: nxt = RUN;
            endcase
        end
    end

    always_comb begin
        inc_h_nxt = 1'b0;
        inc_m_nxt = 1'b0;
        clr_s_nxt = 1'b0;
        if (inc_press || rpt_fire) begin
            case (cur)
                SET_H:   inc_h_nxt = 1'b1;
                SET_M:   inc_m_nxt = 1'b1;
                SET_S:   clr_s_nxt = inc_press;
                default: ;
            endcase
        end
    end

    // Prescaler and blink look at both current and next state so neither output
    // leaks across a mode change, and both restart from zero on entry.
    always_ff @(posedge main_clock) begin
        if (!main_reset) begin
            presc     <= '0;
            tick_1hz  <= 1'b0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            inc_h     <= 1'b0;
            inc_m     <= 1'b0;
            clr_s     <= 1'b0;
        end else begin
            inc_h <= inc_h_nxt;
            inc_m <= inc_m_nxt;
            clr_s <= clr_s_nxt;

            if (cur == RUN && nxt == RUN) begin
                tick_1hz <= (presc == PRESC_LAST);
                presc    <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end else begin
                tick_1hz <= 1'b0;
                presc    <= '0;
            end

            if (cur != RUN && nxt != RUN) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end
        end
    end

    assign state = cur;

endmodule
